// File: rtl/fetch_buffer_unit_pkg.sv
// fetch_buffer_unit_pkg: shared defaults and sizing helper for the fetch front end
package fetch_buffer_unit_pkg;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_INST_W = 32;
    localparam int unsigned DEF_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;
    localparam int unsigned DEF_PC_STEP = 4;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_buffer_unit_if.sv
// fetch_buffer_unit_if: ROM, redirect and id-stage signals of the fetch front end
interface fetch_buffer_unit_if
    import fetch_buffer_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W,
    parameter int DEPTH = DEF_DEPTH
);
    logic rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_data_i;
    logic branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic id_valid_o;
    logic id_ready_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic [cnt_w(DEPTH)-1:0] fifo_count_o;
    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_count_o,
        input rom_data_i, branch_flag_i, branch_target_i, id_ready_i
    );
    modport slave (
        input rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_count_o,
        output rom_data_i, branch_flag_i, branch_target_i, id_ready_i
    );
endinterface

// File: rtl/fetch_buffer_unit_fifo.sv
// fetch_buffer_unit_fifo: synchronous FIFO with push/pop/clear, count and zeroed head when empty
module fetch_buffer_unit_fifo
    import fetch_buffer_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        rd_d = clear_i ? '0 : rd_q + PW'(pop_i);
        wr_d = clear_i ? '0 : wr_q + PW'(push_i);
        count_d = clear_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !clear_i && !rst) mem_q[wr_q] <= data_i;
    end
    assign count_o = count_q;
    assign data_o = (count_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit: PC generator and instruction queue between instruction ROM and id stage
module fetch_buffer_unit
    import fetch_buffer_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned PC_STEP = DEF_PC_STEP
) (
    input logic clk,
    input logic rst,
    fetch_buffer_unit_if.master bus
);
    localparam int CW = cnt_w(DEPTH);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic ce_q;
    logic [CW-1:0] count;
    logic [ADDR_W+INST_W-1:0] head;
    logic valid, full, pop, push;
    always_comb begin
        valid = count != '0;
        full = count == CW'(DEPTH);
        pop = valid & bus.id_ready_i;
        push = ce_q & ~bus.branch_flag_i & (~full | pop);
        pc_d = bus.branch_flag_i ? (bus.branch_target_i & ~ADDR_W'(3))
             : push ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= 1'b1;
        end
    end
    fetch_buffer_unit_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(push),
        .pop_i(pop),
        .clear_i(bus.branch_flag_i),
        .data_i({pc_q, bus.rom_data_i}),
        .data_o(head),
        .count_o(count)
    );
    assign bus.rom_ce_o = ce_q;
    assign bus.rom_addr_o = ce_q ? pc_q : '0;
    assign bus.id_valid_o = valid;
    assign bus.id_pc_o = head[ADDR_W+INST_W-1:INST_W];
    assign bus.id_inst_o = head[INST_W-1:0];
    assign bus.fifo_count_o = count;
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// tb_fetch_buffer_unit: randomized scoreboard bench for fetch_buffer_unit plus a PC-wrap instance
module tb_fetch_buffer_unit;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int D = 4;
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    ent_t sb[$];
    logic [AW-1:0] m_pc;
    logic m_ce;
    always #5 clk = ~clk;
    fetch_buffer_unit_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D)) bus ();
    fetch_buffer_unit_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D)) bus1 ();
    fetch_buffer_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fetch_buffer_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );
    function automatic logic [IW-1:0] rom_fn(input logic [AW-1:0] a);
        return IW'(a >> 2);
    endfunction
    assign bus.rom_data_i = rom_fn(bus.rom_addr_o);
    assign bus1.rom_data_i = rom_fn(bus1.rom_addr_o);
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Monitor: checks outputs against the queue model, then advances the model across the coming edge
    initial begin
        int n;
        bit pop;
        m_pc = '0;
        m_ce = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            chk("rom_ce", 64'(bus.rom_ce_o), 64'(m_ce));
            chk("rom_addr", 64'(bus.rom_addr_o), m_ce ? 64'(m_pc) : 64'h0);
            chk("count", 64'(bus.fifo_count_o), 64'(sb.size()));
            chk("id_valid", 64'(bus.id_valid_o), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("head_pc", 64'(bus.id_pc_o), 64'(sb[0].pc));
                chk("head_inst", 64'(bus.id_inst_o), 64'(sb[0].inst));
            end else begin
                chk("empty_pc", 64'(bus.id_pc_o), 64'h0);
                chk("empty_inst", 64'(bus.id_inst_o), 64'h0);
            end
            if (rst) begin
                sb.delete();
                m_ce = 1'b0;
                m_pc = '0;
            end else begin
                n = sb.size();
                pop = n != 0 && bus.id_ready_i;
                if (pop) void'(sb.pop_front());
                if (bus.branch_flag_i) begin
                    sb.delete();
                    m_pc = bus.branch_target_i & ~32'h3;
                end else if (m_ce && (n < D || pop)) begin
                    sb.push_back('{m_pc, rom_fn(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
                m_ce = 1'b1;
            end
        end
    end
    // Wrap instance: PCs handed to id must wrap from the top of the address space to zero
    initial begin
        logic [AW-1:0] exp_w [3];
        int k;
        exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        k = 0;
        bus1.id_ready_i = 1'b1;
        bus1.branch_flag_i = 1'b0;
        bus1.branch_target_i = '0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            #2;
            if (bus1.id_valid_o) begin
                chk("wrap_pc", 64'(bus1.id_pc_o), 64'(exp_w[k]));
                chk("wrap_inst", 64'(bus1.id_inst_o), 64'(rom_fn(exp_w[k])));
                k++;
            end
        end
        chk("wrap_seen", 64'(k), 64'd3);
    end
    // Driver: directed scenarios, then random traffic with occasional redirect and reset
    initial begin
        bus.id_ready_i = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.id_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        bus.id_ready_i = 1'b0;
        repeat (8) @(negedge clk);
        bus.id_ready_i = 1'b1;
        @(negedge clk);
        bus.id_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h40;
        @(negedge clk);
        bus.branch_flag_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.branch_flag_i = 1'b1;
        bus.branch_target_i = 32'h103;
        @(negedge clk);
        bus.branch_flag_i = 1'b0;
        bus.id_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        bus.id_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        repeat (3000) begin
            rst = $urandom_range(0, 99) == 0;
            bus.branch_flag_i = $urandom_range(0, 14) == 0;
            bus.branch_target_i = $urandom;
            bus.id_ready_i = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        rst = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.id_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
